// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder
// Front end of the delta-sigma DAC. Signed audio samples are queued in a
// small FIFO, released once per sample period, scaled by an unsigned gain
// with saturation, truncated to N bits and presented to the DAC as an
// offset-binary code that only changes on clock edges.
module dac_sample_feeder #(
    parameter int N     = 8,    // DAC code width
    parameter int W     = 16,   // input sample width, two's complement, W >= N
    parameter int DIV   = 256,  // DAC clocks per sample period, DIV >= 4
    parameter int DEPTH = 4,    // FIFO depth, power of 2, >= 2
    parameter int GW    = 8     // gain width, unity gain = 2**(GW-1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [W-1:0]                 in_sample,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [GW-1:0]                gain,
    input  logic                         mute,
    output logic [N-1:0]                 dac_in,
    output logic                         sample_tick,
    output logic                         underrun,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);       // FIFO pointer width
    localparam int LW = $clog2(DEPTH + 1);   // FIFO occupancy width
    localparam int CW = $clog2(DIV);         // tick counter width
    localparam int PW = W + GW + 1;          // signed product width

    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [N-1:0]  MIDSCALE = {1'b1, {(N-1){1'b0}}};
    localparam logic [W-1:0]  SAT_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  SAT_NEG  = {1'b1, {(W-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [W-1:0]  held_q,   held_d;
    logic [W-1:0]  stage1_q, stage1_d;
    logic [N-1:0]  dac_q,    dac_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic          tick;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;

    logic signed [PW-1:0] held_ext;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;
    logic [GW+1:0]        upper;
    logic [N-1:0]         trunc;

    // Handshake and sequencing decisions, all from registered state.
    always_comb begin
        tick       = (cnt_q == CNT_MAX);
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_FULL);
        // A full FIFO refuses the write even when a pop happens this cycle.
        push       = in_valid && !fifo_full;
        // A tick that finds the FIFO empty does not pop, even if a write
        // arrives in the same cycle; that write is simply stored.
        pop        = tick && !fifo_empty;
    end

    // Sample-period counter: 0..DIV-1, tick on the last count.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        held_d   = held_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            held_d   = mem[rd_ptr_q];
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Stage 1: gain multiply, rescale by 2**(GW-1), saturate to W bits.
    always_comb begin
        held_ext = {{(GW+1){held_q[W-1]}}, held_q};
        gain_ext = {{(W+1){1'b0}}, gain};
        prod     = held_ext * gain_ext;
        scaled   = prod >>> (GW - 1);
        // The value fits in W signed bits when everything above bit W-2
        // is a copy of the sign bit.
        upper    = scaled[PW-1:W-1];
        if ((&upper) || !(|upper)) begin
            stage1_d = W'(scaled);
        end else if (scaled[PW-1]) begin
            stage1_d = SAT_NEG;
        end else begin
            stage1_d = SAT_POS;
        end
    end

    // Stage 2: keep the top N bits, flip the MSB for offset binary, mute.
    always_comb begin
        trunc = N'(stage1_q >> (W - N));
        dac_d = mute ? MIDSCALE : (trunc ^ MIDSCALE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Control, held-sample and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register sees the pre-edge value of every other register.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            held_q   <= '0;
            stage1_q <= '0;
            dac_q    <= MIDSCALE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            held_q   <= held_d;
            stage1_q <= stage1_d;
            dac_q    <= dac_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the pointers and level
        // define which entries are valid, so stale contents are never read.
        if (!reset && push) begin
            mem[wr_ptr_q] <= in_sample;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = !fifo_full;
    assign sample_tick = tick;
    assign underrun    = tick && fifo_empty;
    assign fifo_level  = level_q;
    assign dac_in      = dac_q;

endmodule

// File: doc/dac_sample_feeder.md
Name: dac_sample_feeder

Overview:
- Upstream stage of the delta-sigma DAC. It buffers signed audio samples from the voice/mixer path in a small FIFO.
- Samples are released at a fixed sample rate derived from the DAC clock. Each released sample has gain applied with saturation.
- The result is converted to the N-bit offset-binary (excess 2**(N-1)) code the DAC consumes. The code is held steady between sample ticks.

Parameters:
- N, 8, DAC input width; must equal the downstream DAC's N.
- W, 16, input sample width, two's complement; W >= N.
- DIV, 256, DAC clocks per sample period; DIV >= 4.
- DEPTH, 4, FIFO depth; power of 2, >= 2.
- GW, 8, gain width, unsigned; unity gain = 2**(GW-1).

Ports:
- clk  input  1  DAC clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- in_sample  input  W  signed audio sample.
- in_valid  input  1  in_sample valid.
- in_ready  output  1  FIFO can accept a sample.
- gain  input  GW  volume, unsigned, 2**(GW-1) = x1.0.
- mute  input  1  force midscale output.
- dac_in  output  N  offset-binary code to the DAC.
- sample_tick  output  1  one-cycle pulse per sample period.
- underrun  output  1  one-cycle pulse when a tick finds the FIFO empty.
- fifo_level  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset is synchronous and active-high; clk is the single clock. While reset is high at a rising edge, all state takes its reset value:
  - FIFO empty, fifo_level=0, in_ready=1.
  - Tick counter=0, sample_tick=0, underrun=0.
  - Held sample=0, pipeline registers=0.
  - dac_in = 2**(N-1) (midscale).
- Reset mid-operation flushes the FIFO and discards in-flight pipeline data. Writes presented during reset are dropped.
- Handshake:
  - in_ready = (fifo_level != DEPTH), computed from registered state.
  - A push occurs on a rising edge with in_valid && in_ready. in_sample must be held while in_valid && !in_ready.
  - When the FIFO is full, no push occurs even if a pop happens in the same cycle.
  - Push and pop in the same cycle with level < DEPTH: both occur and the level is unchanged.
  - Push into an empty FIFO on a tick cycle: the pop sees the empty state, so underrun fires and the new sample is stored.
- Tick counter:
  - Counts 0..DIV-1 and wraps to 0.
  - sample_tick is high during the cycle count==DIV-1. The first tick is DIV cycles after reset release.
- On a tick cycle:
  - FIFO non-empty: pop the head into the held-sample register.
  - FIFO empty: keep the held sample and pulse underrun for that cycle.
- Stage 1 (register after the held sample):
  - p = held_sample * {1'b0, gain}, signed, W+GW+1 bits.
  - Arithmetic shift right by GW-1.
  - Saturate to the W-bit signed range [-2**(W-1), 2**(W-1)-1].
  - The gain value used is the one sampled at this stage.
- Stage 2 (output register):
  - s = sat[W-1 : W-N], truncation with no rounding.
  - dac_in = s with its MSB inverted.
  - If mute=1 at this stage, dac_in = 2**(N-1).
- Latency and update timing:
  - dac_in reflects a popped sample at the 3rd rising edge after the edge that samples sample_tick high (pop edge plus 2 pipeline edges).
  - Stage registers update every cycle, so gain and mute changes reach dac_in within 2 clocks with no tick required.
- Underrun is non-destructive: the output stays at the last value, scaled by the current gain and mute.
- fifo_level and in_ready update on the same edge as a push or pop.
- dac_in is registered and glitch-free, and changes at most once per clock.

Test Plan (N=8, W=16, DIV=8, DEPTH=4, GW=8):
- Reset held 2 cycles then released -> dac_in=0x80, in_ready=1, fifo_level=0, sample_tick first high 8 cycles later.
- Push 0x4000, gain=0x80, mute=0 -> at next tick fifo_level goes 1->0; dac_in=0xC0 exactly 3 edges after the tick edge. Push 0xC000 -> dac_in=0x40.
- Saturation with gain=0xFF:
  - Push 0x7000 -> dac_in=0xFF.
  - Push 0x9000 -> dac_in=0x00.
  - Push 0x0100 -> dac_in=0x81 (0x01FE truncated to 0x01).
- Full FIFO: 5 back-to-back pushes with no intervening tick -> in_ready=0 after the 4th, fifo_level=4, 5th accepted only after the next tick pops. Push+pop on the same edge at level 2 -> level stays 2.
- Underrun: FIFO empty at a tick -> underrun high for exactly that cycle, dac_in unchanged. Push 0x2000 on the tick cycle -> underrun=1 and fifo_level=1 afterwards.
- Mute/gain live update: mute=1 -> dac_in=0x80 within 2 clocks. Mute=0 restores the prior code. Gain 0x80->0x40 on held 0x4000 -> dac_in 0xC0->0xA0 within 2 clocks. Reset asserted mid-stream -> FIFO flushed, dac_in=0x80.
